// File: rtl/setpoint_sequencer.sv
// rtl/setpoint_sequencer.sv - steps the current-reference solver through a table of Q setpoints
// and reports the converged (or timed-out) i_ref for each point.
module setpoint_sequencer #(
  parameter int BUS_WIDTH      = 10,
  parameter int DEPTH          = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [BUS_WIDTH-1:0]       cfg_data,
  input  logic [$clog2(DEPTH):0]     num_points,
  input  logic                       start,
  input  logic                       abort,
  output logic [BUS_WIDTH-1:0]       q_desired,
  output logic                       solver_rst,
  output logic                       solver_ready,
  input  logic                       solver_converged,
  input  logic [BUS_WIDTH-1:0]       solver_i_ref,
  output logic                       res_valid,
  output logic [$clog2(DEPTH)-1:0]   res_index,
  output logic [BUS_WIDTH-1:0]       res_i_ref,
  output logic                       res_timeout,
  output logic                       busy,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   N_MAX  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SRST,
    SETTLE,
    RUN,
    CAPTURE
  } state_t;

  state_t               state;
  logic [BUS_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]          n_lat;
  logic [AW:0]          idx;
  logic [AW:0]          n_req;
  logic [SW-1:0]        scnt;
  logic [TW-1:0]        tcnt;
  logic [BUS_WIDTH-1:0] i_ref_prev;
  logic                 rec_prev;
  logic                 decide;

  assign n_req  = (num_points > N_MAX) ? N_MAX : num_points;
  assign decide = solver_converged || (tcnt == T_LAST);

  // The table has no reset; it is only meaningful once written.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      n_lat        <= '0;
      idx          <= '0;
      scnt         <= '0;
      tcnt         <= '0;
      i_ref_prev   <= '0;
      rec_prev     <= 1'b0;
      q_desired    <= '0;
      solver_rst   <= 1'b0;
      solver_ready <= 1'b0;
      res_valid    <= 1'b0;
      res_index    <= '0;
      res_i_ref    <= '0;
      res_timeout  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      solver_rst <= 1'b0;
      res_valid  <= 1'b0;
      if (abort && state != IDLE) begin
        state        <= IDLE;
        busy         <= 1'b0;
        solver_ready <= 1'b0;
        rec_prev     <= 1'b0;
      end else begin
        if ((state == SETTLE || state == RUN) && tcnt != T_LAST) begin
          tcnt <= tcnt + TW'(1);
        end
        case (state)
          IDLE: begin
            if (start) begin
              n_lat <= n_req;
              idx   <= '0;
              done  <= (n_req == '0);
              if (n_req != '0) begin
                busy  <= 1'b1;
                state <= LOAD;
              end
            end
          end
          LOAD: begin
            q_desired  <= mem[idx[AW-1:0]];
            tcnt       <= '0;
            solver_rst <= 1'b1;
            state      <= SRST;
          end
          SRST: begin
            scnt     <= '0;
            rec_prev <= 1'b1;
            state    <= SETTLE;
          end
          SETTLE: begin
            // The solver's post-reset i_ref is the baseline for change detection.
            if (rec_prev) begin
              i_ref_prev <= solver_i_ref;
              rec_prev   <= 1'b0;
            end
            if (scnt == S_LAST) begin
              solver_ready <= 1'b1;
              state        <= RUN;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
          RUN: begin
            if (decide) begin
              res_valid    <= 1'b1;
              res_index    <= idx[AW-1:0];
              res_i_ref    <= solver_i_ref;
              res_timeout  <= !solver_converged;
              solver_ready <= 1'b0;
              state        <= CAPTURE;
            end else if (solver_i_ref != i_ref_prev) begin
              // New i_ref: let the measured Q settle before the solver looks again.
              i_ref_prev   <= solver_i_ref;
              scnt         <= '0;
              solver_ready <= 1'b0;
              state        <= SETTLE;
            end
          end
          CAPTURE: begin
            if (idx == n_lat - (AW+1)'(1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx   <= idx + (AW+1)'(1);
              state <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_setpoint_sequencer.sv
// tb/tb_setpoint_sequencer.sv - directed and randomized bench with a procedural reference model
module tb_setpoint_sequencer;

  localparam int BW    = 10;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int S     = 4;
  localparam int T     = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [BW-1:0] cfg_data = '0;
  logic [AW:0]   num_points = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] q_desired;
  logic          solver_rst;
  logic          solver_ready;
  logic          solver_converged = 1'b0;
  logic [BW-1:0] solver_i_ref = '0;
  logic          res_valid;
  logic [AW-1:0] res_index;
  logic [BW-1:0] res_i_ref;
  logic          res_timeout;
  logic          busy;
  logic          done;
  logic [29:0]   outs;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int srst_cnt = 0;
  int ready_cnt = 0;
  int vcount = 0;

  setpoint_sequencer #(
    .BUS_WIDTH(BW), .DEPTH(DEPTH), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .num_points(num_points), .start(start), .abort(abort), .q_desired(q_desired),
    .solver_rst(solver_rst), .solver_ready(solver_ready), .solver_converged(solver_converged),
    .solver_i_ref(solver_i_ref), .res_valid(res_valid), .res_index(res_index),
    .res_i_ref(res_i_ref), .res_timeout(res_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign outs = {q_desired, solver_rst, solver_ready, res_valid, res_index,
                 res_i_ref, res_timeout, busy, done};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: walks each run as nested loops over points and cycles.
  logic [BW-1:0] mtab [DEPTH];
  logic [BW-1:0] e_q, e_iref, s_iref, s_data;
  logic [AW-1:0] e_idx, s_addr;
  logic [AW:0]   s_np;
  logic          e_srst, e_ready, e_rv, e_tmo, e_busy, e_done;
  logic          s_conv, s_abort, s_we, s_start;
  bit            got_rst;

  task automatic clear_exp();
    e_q = '0; e_iref = '0; e_idx = '0;
    e_srst = 0; e_ready = 0; e_rv = 0; e_tmo = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic step(output bit stop);
    @(posedge clk or posedge rst);
    if (rst) begin
      clear_exp();
      got_rst = 1;
      stop = 1;
    end else begin
      s_conv = solver_converged; s_iref = solver_i_ref; s_abort = abort;
      s_we = cfg_we; s_addr = cfg_addr; s_data = cfg_data;
      s_start = start; s_np = num_points;
      stop = 0;
    end
  endtask

  task automatic bstep(output bit stop);
    step(stop);
    if (!stop && s_abort) begin
      e_busy = 0; e_ready = 0; e_srst = 0; e_rv = 0;
      stop = 1;
    end
  endtask

  task automatic run_points(input int n);
    bit stop;
    bit decided;
    int k;
    logic [BW-1:0] prev;
    for (int p = 0; p < n; p++) begin
      bstep(stop); if (stop) return;
      e_q = mtab[p]; e_srst = 1;
      bstep(stop); if (stop) return;
      e_srst = 0;
      k = 0; decided = 0; prev = '0;
      for (int s = 0; s < S; s++) begin
        bstep(stop); if (stop) return;
        if (s == 0) prev = s_iref;
        k++;
      end
      e_ready = 1;
      while (!decided) begin
        bstep(stop); if (stop) return;
        if (s_conv || k >= T - 1) begin
          decided = 1;
          e_rv = 1; e_idx = AW'(p); e_iref = s_iref; e_tmo = !s_conv; e_ready = 0;
        end else begin
          k++;
          if (s_iref != prev) begin
            prev = s_iref; e_ready = 0;
            for (int s = 0; s < S; s++) begin
              bstep(stop); if (stop) return;
              k++;
            end
            e_ready = 1;
          end
        end
      end
      bstep(stop); if (stop) return;
      e_rv = 0;
      if (p == n - 1) begin
        e_done = 1; e_busy = 0;
      end
    end
  endtask

  initial begin : ref_model
    bit stop;
    int n;
    clear_exp();
    forever begin
      got_rst = 0;
      wait (!rst);
      while (!got_rst) begin
        step(stop);
        if (!stop) begin
          if (s_we) mtab[s_addr] = s_data;
          if (s_start) begin
            n = (int'(s_np) > DEPTH) ? DEPTH : int'(s_np);
            e_done = (n == 0);
            if (n != 0) begin
              e_busy = 1;
              run_points(n);
            end
          end
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) check("cycle", outs, {e_q, e_srst, e_ready, e_rv, e_idx, e_iref, e_tmo, e_busy, e_done});
    end
  end

  initial begin : monitors
    forever begin
      @(negedge clk);
      if (solver_rst) srst_cnt++;
      if (solver_ready) ready_cnt++;
      if (res_valid) vcount++;
    end
  end

  // Solver stand-in: 0 converges 5 cycles after reset, 1 never converges,
  // 2 walks i_ref 512->256->384 then converges, 3 random.
  initial begin : solver
    int cnt, rcnt;
    cnt = 0; rcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        solver_converged = 0; solver_i_ref = '0; cnt = 0; rcnt = 0;
      end else if (solver_rst) begin
        cnt = 0; rcnt = 0; solver_converged = 0;
        solver_i_ref = (mode == 2) ? BW'(512) : q_desired + BW'(7);
      end else begin
        cnt++;
        if (solver_ready) rcnt++;
        case (mode)
          0: solver_converged = (cnt >= 5);
          1: solver_converged = 0;
          2: begin
            if (rcnt == 2) solver_i_ref = BW'(256);
            if (rcnt == 4) solver_i_ref = BW'(384);
            solver_converged = (rcnt >= 6);
          end
          default: begin
            solver_converged = solver_ready && ($urandom_range(0, 9) == 0);
            if (solver_ready ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0))
              solver_i_ref = BW'($urandom);
          end
        endcase
      end
    end
  end

  task automatic write_tab(input int a, input int d);
    cfg_we = 1; cfg_addr = AW'(a); cfg_data = BW'(d);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic do_start(input int n);
    num_points = (AW+1)'(n); start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_valid(input int budget, inout int t, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (res_valid) begin
        ok = 1;
        return;
      end
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    checks++;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    int t, base, rbase;
    bit ok;
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 0);
    rst = 0;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) write_tab(a, $urandom_range(0, 1023));
    write_tab(0, 110); write_tab(1, 130); write_tab(2, 150);

    // three points, converging in the first RUN cycle
    mode = 0; base = srst_cnt;
    do_start(3); t = 1;
    for (int p = 0; p < 3; p++) begin
      wait_valid(40, t, ok);
      check("t1_seen", ok, 1);
      check("t1_lat", t, 8 * (p + 1));
      check("t1_index", res_index, p);
      check("t1_iref", res_i_ref, 117 + 20 * p);
      check("t1_model_iref", e_iref, 117 + 20 * p);
      check("t1_tmo", res_timeout, 0);
      @(negedge clk); t++;
    end
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    check("t1_srst_pulses", srst_cnt - base, 3);

    // never converges: timeout 64 cycles after SETTLE entry
    mode = 1;
    write_tab(0, 200); write_tab(1, 300);
    do_start(2); t = 1;
    wait_valid(100, t, ok);
    check("t2_seen0", ok, 1);
    check("t2_lat0", t, 67);
    check("t2_tmo0", res_timeout, 1);
    check("t2_iref0", res_i_ref, 207);
    @(negedge clk); t++;
    wait_valid(100, t, ok);
    check("t2_seen1", ok, 1);
    check("t2_lat1", t, 134);
    check("t2_tmo1", res_timeout, 1);
    check("t2_index1", res_index, 1);
    @(negedge clk);
    check("t2_done", done, 1);

    // i_ref moves twice; each change re-settles for S cycles
    mode = 2; rbase = ready_cnt;
    write_tab(0, 50);
    do_start(1); t = 1;
    wait_valid(60, t, ok);
    check("t3_seen", ok, 1);
    check("t3_lat", t, 21);
    check("t3_iref", res_i_ref, 384);
    check("t3_tmo", res_timeout, 0);
    check("t3_ready_cycles", ready_cnt - rbase, 6);
    @(negedge clk);

    // abort during RUN of point 1
    mode = 0; base = vcount;
    do_start(3); t = 1;
    while (t < 15) begin @(negedge clk); t++; end
    check("t4_in_run", solver_ready, 1);
    check("t4_one_result", vcount - base, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_valid", res_valid, 0);
    check("t4_ready", solver_ready, 0);
    repeat (3) @(negedge clk);
    check("t4_no_more", vcount - base, 1);
    do_start(1); t = 1;
    wait_valid(40, t, ok);
    check("t4_rerun_seen", ok, 1);
    check("t4_rerun_lat", t, 8);
    check("t4_rerun_index", res_index, 0);
    @(negedge clk);

    // zero points, then DEPTH+1 points with writes/starts while busy
    do_start(0);
    check("t5_done0", done, 1);
    check("t5_busy0", busy, 0);
    @(negedge clk);
    check("t5_busy0b", busy, 0);
    base = vcount;
    do_start(DEPTH + 1);
    @(negedge clk);
    cfg_we = 1; cfg_addr = AW'(10); cfg_data = BW'(999); num_points = 2; start = 1;
    @(negedge clk);
    cfg_we = 0; start = 0;
    wait_idle(400, ok);
    check("t5_drain", ok, 1);
    check("t5_results", vcount - base, DEPTH);
    check("t5_done", done, 1);

    // reset asserted mid-SETTLE
    do_start(2);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1 check("t6_rst_outs", outs, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    for (int a = 0; a < DEPTH; a++) write_tab(a, $urandom_range(0, 1023));

    // random traffic
    mode = 3;
    for (int c = 0; c < 6000; c++) begin
      start = ($urandom_range(0, 39) == 0);
      num_points = ($urandom_range(0, 9) == 0) ? (AW+1)'(DEPTH + 1) : (AW+1)'($urandom_range(0, 5));
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = AW'($urandom);
      cfg_data = BW'($urandom);
      abort = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    start = 0; cfg_we = 0; abort = 0;
    wait_idle(3000, ok);
    check("rand_drain", ok, 1);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/setpoint_sequencer.md
# setpoint_sequencer

Sequences the current-reference solver (bisection or secant) through a programmable list of Q setpoints. For each point it loads `q_desired`, resets the solver, and gates the solver `ready` so the measured Q can settle after every `i_ref` change. It then waits for convergence or a timeout and reports the converged `i_ref` per point. It sits between the configuration/host side and the solver in the front-end control path.

## Interface
Parameters:
- `BUS_WIDTH`, 10: width of Q and i_ref buses.
- `DEPTH`, 16: setpoint table entries; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `SETTLE_CYCLES`, 4: cycles `solver_ready` is held low after solver reset and after each `i_ref` change; ≥1.
- `TIMEOUT_CYCLES`, 64: maximum cycles per point, counted in SETTLE+RUN; ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: setpoint table write strobe; accepted only in IDLE.
- `cfg_addr` in AW: table write address.
- `cfg_data` in BUS_WIDTH: setpoint written.
- `num_points` in AW+1: points to run; sampled on `start`.
- `start` in 1: one-cycle start request; accepted only in IDLE.
- `abort` in 1: ends the run immediately.
- `q_desired` out BUS_WIDTH: setpoint driven to the solver.
- `solver_rst` out 1: one-cycle solver reset pulse.
- `solver_ready` out 1: solver enable (drives the solver `ready`).
- `solver_converged` in 1: solver convergence flag.
- `solver_i_ref` in BUS_WIDTH: solver current reference output.
- `res_valid` out 1: one-cycle result strobe.
- `res_index` out AW: table index of the result.
- `res_i_ref` out BUS_WIDTH: `solver_i_ref` captured at convergence or timeout.
- `res_timeout` out 1: result ended by timeout, not convergence.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: set when a run completes normally; cleared on the next accepted `start` or by `rst`.

## Operation
- Reset: all outputs 0, FSM in IDLE, table contents undefined, counters 0.
- States: IDLE, LOAD, SRST, SETTLE, RUN, CAPTURE.
- IDLE:
  - `cfg_we` writes `table[cfg_addr]`.
  - On `start`: latch `n = min(num_points, DEPTH)`, set `idx=0`, clear `done`.
  - If `n==0`: set `done` and stay in IDLE.
  - Otherwise go to LOAD.
- LOAD:
  - `q_desired <= table[idx]`, clear the timeout counter, go to SRST.
- SRST:
  - `solver_rst=1` for this cycle only.
  - Record `i_ref_prev <= solver_i_ref` in the following cycle.
  - Go to SETTLE.
- SETTLE:
  - `solver_ready=0`; count `SETTLE_CYCLES` cycles, then go to RUN.
- RUN:
  - `solver_ready=1`. Evaluate each cycle in priority order:
    1. `solver_converged`: go to CAPTURE with `res_timeout=0`.
    2. Timeout counter = `TIMEOUT_CYCLES-1`: go to CAPTURE with `res_timeout=1`.
    3. `solver_i_ref != i_ref_prev`: update `i_ref_prev`, restart the settle count, go to SETTLE.
- CAPTURE:
  - `res_valid=1`, `res_index=idx`, `res_i_ref` = `solver_i_ref` from the deciding cycle.
  - If `idx==n-1`: set `done`, go to IDLE. Otherwise increment `idx` and go to LOAD.
- Timeout counter: increments every cycle in SETTLE and RUN, saturates, and clears in LOAD.
- `abort` in any non-IDLE state:
  - Go to IDLE on the next edge; `solver_ready` goes to 0.
  - No `res_valid` for the current point; `done` stays 0.
  - Overrides every other condition in the same cycle.
- Ignored inputs: `start` while `busy`; `cfg_we` while `busy` (table unchanged).
- Widths: `res_*` and `q_desired` hold their value between updates. Internally, `idx` is AW+1 bits wide so that `n==DEPTH` terminates correctly.

## Timing
- `start` sampled at edge 0 → LOAD during cycle 1, SRST during cycle 2 (`solver_rst` high), SETTLE during cycles 3..3+S-1, RUN from cycle 3+S.
- Converged on the first RUN cycle → `res_valid` one cycle later. Per-point minimum is 4+S cycles (S = `SETTLE_CYCLES`).
- `q_desired` is stable from cycle 2 of each point until the next LOAD.
- `solver_ready` drops in the cycle after an `i_ref` change is detected.
- `done` rises together with the last `res_valid` edge. `busy` falls on that same edge.
- `rst` asserted mid-run clears everything asynchronously. No result is emitted.

## Test plan
- Table {110,130,150}, `num_points=3`, solver model converging 5 cycles after reset → three `res_valid` pulses with `res_index` 0,1,2 and `res_timeout=0`; `done=1` after the third; `solver_rst` pulsed exactly 3 times.
- Solver model never converges, `TIMEOUT_CYCLES=64` → `res_timeout=1` exactly 64 cycles after the point's SETTLE entry; the run continues to the next point.
- Solver `i_ref` toggles 512→256→384 → `solver_ready` low for 4 cycles after each change; no RUN cycle occurs with a stale `i_ref_prev`.
- `abort` asserted during RUN of point 1 of 3 → IDLE next cycle; `busy=0`, `done=0`, no result for point 1. A later `start` reruns from index 0.
- `num_points=0` → `done=1` the cycle after `start`, `busy` never set. `num_points=DEPTH+1` → exactly DEPTH results.
- `cfg_we` and `start` pulsed while busy → table and run unaffected. `rst` pulsed mid-SETTLE → all outputs 0 immediately.
